seq_tx_1011: RTL and testbench

SEQ_TX_1011 -- requirements
Module: seq_tx_1011

---
 rtl/seq_tx_1011_if.sv | 31 +++
 rtl/seq_tx_1011.sv | 161 ++++++++++++++++
 tb/tb_seq_tx_1011.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/seq_tx_1011_if.sv
// Request/stream bundle for the 1011-preamble serial transmitter.
// master: the side that requests frames and watches the serial stream.
// slave:  the transmitter itself.
interface seq_tx_1011_if #(
    parameter int DATA_W = 8
);
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic              ready;
    logic              out_bit;
    logic              out_valid;
    logic              frame_done;

    modport master (
        output start,
        output data_in,
        input  ready,
        input  out_bit,
        input  out_valid,
        input  frame_done
    );

    modport slave (
        input  start,
        input  data_in,
        output ready,
        output out_bit,
        output out_valid,
        output frame_done
    );
endinterface

// File: rtl/seq_tx_1011.sv
// Serial frame transmitter: preamble 1,0,1,1 followed by a DATA_W-bit
// payload sent MSB first, then GAP idle cycles before the next request can
// be taken. The payload is sent verbatim, so a downstream 1011 detector
// sees the preamble plus any 1011 patterns that occur inside the data.
// Optional feature: define SEQ_TX_PARITY_EN to append one even-parity bit
// (XOR of the payload bits) after the payload.
module seq_tx_1011 #(
    parameter int DATA_W = 8,
    parameter int GAP    = 2
) (
    input  logic          clk,
    input  logic          reset,
    seq_tx_1011_if.slave  bus
);

    // The counter has to hold the largest per-state reload value.
    localparam int CNT_MAX = (DATA_W > 4) ? ((DATA_W > GAP) ? DATA_W : GAP)
                                          : ((GAP > 4) ? GAP : 4);
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int FR_W    = 3 + DATA_W;

    localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] PAY_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // State names describe the bit currently presented on out_bit.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
`ifdef SEQ_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_GAP
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [FR_W-1:0]   frame_sr;
    logic              out_bit_r;
    logic              out_valid_r;
    logic              frame_done_r;
`ifdef SEQ_TX_PARITY_EN
    logic              parity;
`endif

    assign bus.ready      = (state == ST_IDLE);
    assign bus.out_bit    = out_bit_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.frame_done = frame_done_r;

    // Frame sequencer: the outputs are loaded together with the state that
    // describes them, so every output is a plain register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            frame_sr     <= '0;
            out_bit_r    <= 1'b0;
            out_valid_r  <= 1'b0;
            frame_done_r <= 1'b0;
`ifdef SEQ_TX_PARITY_EN
            parity       <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    out_bit_r    <= 1'b0;
                    out_valid_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                    if (bus.start) begin
                        state       <= ST_PREAMBLE;
                        cnt         <= PRE_LAST;
                        out_bit_r   <= 1'b1;
                        out_valid_r <= 1'b1;
                        frame_sr    <= {3'b011, bus.data_in};
`ifdef SEQ_TX_PARITY_EN
                        parity      <= ^bus.data_in;
`endif
                    end
                end

                ST_PREAMBLE: begin
                    out_bit_r   <= frame_sr[FR_W-1];
                    out_valid_r <= 1'b1;
                    frame_sr    <= frame_sr << 1;
                    if (cnt != '0) begin
                        cnt          <= cnt - CNT_ONE;
                        frame_done_r <= 1'b0;
                    end else begin
                        state        <= ST_PAYLOAD;
                        cnt          <= PAY_LAST;
`ifdef SEQ_TX_PARITY_EN
                        frame_done_r <= 1'b0;
`else
                        frame_done_r <= (DATA_W == 1);
`endif
                    end
                end

                ST_PAYLOAD: begin
                    if (cnt != '0) begin
                        cnt          <= cnt - CNT_ONE;
                        out_bit_r    <= frame_sr[FR_W-1];
                        out_valid_r  <= 1'b1;
                        frame_sr     <= frame_sr << 1;
`ifdef SEQ_TX_PARITY_EN
                        frame_done_r <= 1'b0;
`else
                        frame_done_r <= (cnt == CNT_ONE);
`endif
                    end else begin
`ifdef SEQ_TX_PARITY_EN
                        state        <= ST_PARITY;
                        out_bit_r    <= parity;
                        out_valid_r  <= 1'b1;
                        frame_done_r <= 1'b1;
`else
                        state        <= ST_GAP;
                        cnt          <= GAP_LAST;
                        out_bit_r    <= 1'b0;
                        out_valid_r  <= 1'b0;
                        frame_done_r <= 1'b0;
`endif
                    end
                end

`ifdef SEQ_TX_PARITY_EN
                ST_PARITY: begin
                    state        <= ST_GAP;
                    cnt          <= GAP_LAST;
                    out_bit_r    <= 1'b0;
                    out_valid_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                end
`endif

                ST_GAP: begin
                    out_bit_r    <= 1'b0;
                    out_valid_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                    if (cnt != '0) begin
                        cnt <= cnt - CNT_ONE;
                    end else begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state        <= ST_IDLE;
                    cnt          <= '0;
                    out_bit_r    <= 1'b0;
                    out_valid_r  <= 1'b0;
                    frame_done_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_tx_1011.sv
// Testbench for seq_tx_1011 (DATA_W=8, GAP=2). Expected frames are written
// out by hand; build with SEQ_TX_PARITY_EN to exercise the parity variant.
module tb_seq_tx_1011;

    localparam int DATA_W = 8;
    localparam int GAP    = 2;

`ifdef SEQ_TX_PARITY_EN
    localparam int          FL       = 13;
    localparam logic [15:0] FRAME_A5 = 16'b000_1011_1010_0101_0;
    localparam logic [15:0] FRAME_00 = 16'b000_1011_0000_0000_0;
    localparam logic [15:0] FRAME_01 = 16'b000_1011_0000_0001_1;
    localparam logic [15:0] FRAME_0B = 16'b000_1011_0000_1011_1;
`else
    localparam int          FL       = 12;
    localparam logic [15:0] FRAME_A5 = 16'b0000_1011_1010_0101;
    localparam logic [15:0] FRAME_00 = 16'b0000_1011_0000_0000;
    localparam logic [15:0] FRAME_01 = 16'b0000_1011_0000_0001;
    localparam logic [15:0] FRAME_0B = 16'b0000_1011_0000_1011;
`endif
    localparam logic [15:0] PART_A5 = 16'b0000_0000_0101_1101;

    typedef struct packed {
        logic b;
        logic done;
    } exp_t;

    logic clk = 1'b0;
    logic reset;

    int   checks = 0;
    int   errors = 0;
    int   cycle  = 0;
    int   hits   = 0;
    logic [3:0] hist = 4'b0000;
    exp_t exp_q[$];
    int   done_times[$];

    seq_tx_1011_if #(.DATA_W(DATA_W)) bus ();

    seq_tx_1011 #(.DATA_W(DATA_W), .GAP(GAP)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, 10 time units per cycle.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Queue the expected bits, MSB of the used slice first.
    task automatic pushBits(input logic [15:0] bits, input int len, input logic last_done);
        exp_t e;
        for (int i = len - 1; i >= 0; i--) begin
            e.b    = bits[i];
            e.done = (i == 0) ? last_done : 1'b0;
            exp_q.push_back(e);
        end
    endtask

    // Issue one start pulse at a negedge with ready high; returns at the
    // negedge showing the first frame bit.
    task automatic applyStimulus(input logic [7:0] data, input logic [15:0] bits,
                                 input int len, input logic last_done);
        bus.start   = 1'b1;
        bus.data_in = data;
        pushBits(bits, len, last_done);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitReady(output int low_cycles);
        low_cycles = 0;
        while (!bus.ready && low_cycles < 200) begin
            @(negedge clk);
            low_cycles++;
        end
        checkOutput("ready_returns", int'(bus.ready), 1);
    endtask

    // Monitor: scoreboard pop on every valid bit, idle checks, and a
    // reference 1011 detector on the raw serial line.
    always @(negedge clk) begin
        exp_t e;
        cycle++;
        hist = {hist[2:0], bus.out_bit};
        if (hist == 4'b1011) hits++;
        if (bus.frame_done) done_times.push_back(cycle);
        if (bus.out_valid) begin
            checkOutput("bit_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput("out_bit", int'(bus.out_bit), int'(e.b));
                checkOutput("frame_done", int'(bus.frame_done), int'(e.done));
            end
        end else begin
            checkOutput("idle_out_bit", int'(bus.out_bit), 0);
            checkOutput("idle_frame_done", int'(bus.frame_done), 0);
        end
    end

    // Global time limit so the bench always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenarios.
    initial begin
        int low;
        int vcnt;
        int base;
        int n;
        int cyc;

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.data_in = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_ready", int'(bus.ready), 1);
        checkOutput("reset_out_valid", int'(bus.out_valid), 0);
        checkOutput("reset_out_bit", int'(bus.out_bit), 0);
        checkOutput("reset_frame_done", int'(bus.frame_done), 0);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] basic frame 0xA5");
        base = done_times.size();
        applyStimulus(8'hA5, FRAME_A5, FL, 1'b1);
        vcnt = 0;
        low  = 0;
        while (!bus.ready && low < 200) begin
            vcnt += int'(bus.out_valid);
            @(negedge clk);
            low++;
        end
        checkOutput("ready_low_cycles", low, FL + GAP);
        checkOutput("valid_cycles", vcnt, FL);
        checkOutput("frames_done_a5", done_times.size() - base, 1);

        $display("[TB] start ignored while busy");
        base = done_times.size();
        applyStimulus(8'hA5, FRAME_A5, FL, 1'b1);
        repeat (4) @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 8'hFF;
        @(negedge clk);
        bus.start = 1'b0;
        waitReady(low);
        repeat (20) @(negedge clk);
        checkOutput("frames_done_busy", done_times.size() - base, 1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'hA5, PART_A5, 7, 1'b0);
        repeat (6) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("abort_out_valid", int'(bus.out_valid), 0);
        checkOutput("abort_ready", int'(bus.ready), 1);
        reset = 1'b0;
        checkOutput("abort_queue_drained", exp_q.size(), 0);
        applyStimulus(8'h00, FRAME_00, FL, 1'b1);
        waitReady(low);

        $display("[TB] payload 0x01");
        applyStimulus(8'h01, FRAME_01, FL, 1'b1);
        waitReady(low);

        $display("[TB] start held high with 0x0B");
        base = done_times.size();
        hits = 0;
        bus.start   = 1'b1;
        bus.data_in = 8'h0B;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 200) begin
            if (bus.ready) begin
                pushBits(FRAME_0B, FL, 1'b1);
                n++;
            end
            @(negedge clk);
            cyc++;
        end
        bus.start = 1'b0;
        checkOutput("held_start_frames_issued", n, 3);
        waitReady(low);
        repeat (3) @(negedge clk);
        checkOutput("held_frames_done", done_times.size() - base, 3);
        if (done_times.size() - base == 3) begin
            checkOutput("frame_period_1", done_times[base + 1] - done_times[base], FL + GAP + 1);
            checkOutput("frame_period_2", done_times[base + 2] - done_times[base + 1], FL + GAP + 1);
        end
        checkOutput("detector_hits", hits, 6);

        $display("[TB] reset and start together");
        reset       = 1'b1;
        bus.start   = 1'b1;
        bus.data_in = 8'hFF;
        @(negedge clk);
        checkOutput("rs_ready", int'(bus.ready), 1);
        checkOutput("rs_out_valid", int'(bus.out_valid), 0);
        reset     = 1'b0;
        bus.start = 1'b0;
        vcnt = 0;
        repeat (6) begin
            @(negedge clk);
            vcnt += int'(bus.out_valid);
        end
        checkOutput("rs_valid_cycles", vcnt, 0);

        repeat (3) @(negedge clk);
        checkOutput("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
